// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback/commit stage: CP0 ExcCode values,
// FSM state encoding and the exception-bit to ExcCode mapping.
package wb_commit_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } wb_state_t;

  // ExcCode reported for exception source bit idx (bit0 = highest priority)
  function automatic logic [4:0] exc_code_of(input int idx);
    case (idx)
      0:       return EXC_INT;
      1:       return EXC_ADEL;
      2:       return EXC_ADES;
      3:       return EXC_OV;
      4:       return EXC_SYS;
      5:       return EXC_BP;
      6:       return EXC_RI;
      default: return EXC_INT;
    endcase
  endfunction

  // Address-error sources are the ones that carry a BadVAddr
  function automatic logic is_addr_err_bit(input int idx);
    return (idx == 1) || (idx == 2);
  endfunction

endpackage

// File: rtl/wb_exc_prio_enc.sv
// Combinational priority encoder over the exception source bits.
// Lowest set bit wins; reports {any, ExcCode, winner-is-address-error}.
module wb_exc_prio_enc
  import wb_commit_pkg::*;
#(
  parameter int N_EXC = 7
) (
  input  logic [N_EXC-1:0] i_except,
  output logic             o_any,
  output logic [4:0]       o_code,
  output logic             o_is_addr_err
);

  // Scan from the lowest-priority bit upward so the lowest set bit is written last
  always_comb begin
    o_any         = |i_except;
    o_code        = EXC_INT;
    o_is_addr_err = 1'b0;
    for (int i = N_EXC - 1; i >= 0; i--) begin
      if (i_except[i]) begin
        o_code        = exc_code_of(i);
        o_is_addr_err = is_addr_err_bit(i);
      end
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Registered writeback/commit stage: regfile write port, CP0 exception
// report, timed flush after a fault and a saturating exception counter.
// Optional feature: define WB_BADVADDR_EN to capture BadVAddr on AdEL/AdES.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int N_EXC     = 7,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_d1,
  input  logic [DATA_W-1:0] in_d2,
  input  logic              in_mem_to_reg,
  input  logic              in_wen,
  input  logic [4:0]        in_wdest,
  input  logic [N_EXC-1:0]  in_except,
  input  logic              in_bd,
  input  logic [DATA_W-1:0] in_badvaddr,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [DATA_W-1:0] exc_epc,
  output logic              exc_bd,
  output logic [DATA_W-1:0] exc_badvaddr,
  output logic              flush,
  output logic [CNT_W-1:0]  exc_cnt
);

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);

  wb_state_t         r_state, w_state_next;
  logic [FC_W-1:0]   r_fcnt, w_fcnt_next;
  logic              r_flush;
  logic              w_accept, w_fault, w_any, w_is_addr_err;
  logic [4:0]        w_code;

  logic              r_rf_we;
  logic [4:0]        r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_exc_valid;
  logic [4:0]        r_exc_code;
  logic [DATA_W-1:0] r_exc_epc;
  logic              r_exc_bd;
  logic [CNT_W-1:0]  r_exc_cnt;

  wb_exc_prio_enc #(.N_EXC(N_EXC)) u_prio (
    .i_except      (in_except),
    .o_any         (w_any),
    .o_code        (w_code),
    .o_is_addr_err (w_is_addr_err)
  );

  assign in_ready = (r_state == ST_RUN);
  assign w_accept = in_valid && in_ready;
  assign w_fault  = w_accept && w_any;

  // Next-state: a faulting accept starts the flush window, countdown ends it
  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (w_fault) begin
          w_state_next = ST_FLUSH;
          w_fcnt_next  = FC_LOAD;
        end
      end
      ST_FLUSH: begin
        if (r_fcnt == '0) w_state_next = ST_RUN;
        else              w_fcnt_next  = r_fcnt - FC_W'(1);
      end
    endcase
  end

  // State register; flush is registered so it rises together with exc_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_fcnt  <= w_fcnt_next;
      r_flush <= (w_state_next == ST_FLUSH);
    end
  end

  // Regfile write port: one-cycle pulse for clean commits to a non-zero register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_accept && !w_any && in_wen && (in_wdest != 5'd0);
      if (w_accept) begin
        r_rf_waddr <= in_wdest;
        r_rf_wdata <= in_mem_to_reg ? in_d1 : in_d2;
      end
    end
  end

  // CP0 report: one-cycle exc_valid with code, EPC (rewound in delay slots) and BD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exc_valid <= 1'b0;
      r_exc_code  <= '0;
      r_exc_epc   <= '0;
      r_exc_bd    <= 1'b0;
    end else begin
      r_exc_valid <= w_fault;
      if (w_fault) begin
        r_exc_code <= w_code;
        r_exc_epc  <= in_bd ? (in_pc - DATA_W'(4)) : in_pc;
        r_exc_bd   <= in_bd;
      end
    end
  end

  // Committed-exception counter, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exc_cnt <= '0;
    end else if (w_fault && (r_exc_cnt != '1)) begin
      r_exc_cnt <= r_exc_cnt + CNT_W'(1);
    end
  end

`ifdef WB_BADVADDR_EN
  logic [DATA_W-1:0] r_exc_badvaddr;

  // BadVAddr only changes when the winning source is an address error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exc_badvaddr <= '0;
    end else if (w_fault && w_is_addr_err) begin
      r_exc_badvaddr <= in_badvaddr;
    end
  end

  assign exc_badvaddr = r_exc_badvaddr;
`else
  logic w_unused_badvaddr;
  assign w_unused_badvaddr = ^{in_badvaddr, w_is_addr_err};
  assign exc_badvaddr      = '0;
`endif

  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign exc_valid = r_exc_valid;
  assign exc_code  = r_exc_code;
  assign exc_epc   = r_exc_epc;
  assign exc_bd    = r_exc_bd;
  assign flush     = r_flush;
  assign exc_cnt   = r_exc_cnt;

endmodule
